// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  localparam int LINE_WORDS      = 4;
  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 8;
  localparam int MEM_LAT_DEFAULT = 4;
  // Wide enough for the largest legal latency load value (MEM_LAT-1 <= 14).
  localparam int CTR_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    WRACK
  } state_t;

endpackage

// File: rtl/mem_lat_ctr.sv
// Latency down-counter: loaded when a request is accepted, counts down while
// the responder waits, and flags zero to release the response phase.
module mem_lat_ctr
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CTR_W-1:0] count;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a cache controller: single-word writes and 4-word line
// reads, each answered after MEM_LAT wait cycles. Storage survives reset.
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int DEPTH   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic [1:0]        MWordIdx,
  output logic              MRdy,
  output logic              MBusy
);

  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CTR_W-1:0] LAT_LOAD = CTR_W'(MEM_LAT - 1);
  localparam logic [1:0]       LAST_IDX = 2'(LINE_WORDS - 1);

  state_t            state;
  logic              cap_rw;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [1:0]        burst_idx;
  logic              ctr_load;
  logic              ctr_dec;
  logic              ctr_zero;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage index of a word; upper address bits wrap for small DEPTH.
  function automatic logic [AW-1:0] word_sel(input logic [ADDR_W-1:0] a);
    return a[AW-1:0];
  endfunction

  // Word idx of the line containing a; the low address bits are replaced.
  function automatic logic [AW-1:0] line_word(input logic [ADDR_W-1:0] a,
                                              input logic [1:0]        idx);
    logic [ADDR_W-1:0] full;
    full = {a[ADDR_W-1:2], idx};
    return full[AW-1:0];
  endfunction

  assign ctr_load = (state == IDLE) && MStrobe;
  assign ctr_dec  = (state == WAIT);
  assign MBusy    = (state != IDLE);

  mem_lat_ctr u_lat_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (LAT_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // Write commits at the end of the WRACK cycle; a reset drops the FSM out of
  // WRACK immediately, so an aborted write never reaches storage.
  always_ff @(posedge clk) begin
    if (state == WRACK) begin
      mem[word_sel(cap_addr)] <= cap_data;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_rw    <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      burst_idx <= '0;
      MRdy      <= 1'b0;
      MDataOut  <= '0;
      MWordIdx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          MRdy     <= 1'b0;
          MDataOut <= '0;
          MWordIdx <= '0;
          if (MStrobe) begin
            cap_rw   <= MRW;
            cap_addr <= MAddr;
            cap_data <= MDataIn;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (ctr_zero) begin
            MRdy <= 1'b1;
            if (cap_rw) begin
              state     <= BURST;
              burst_idx <= '0;
              MWordIdx  <= '0;
              MDataOut  <= mem[line_word(cap_addr, 2'd0)];
            end else begin
              state    <= WRACK;
              MWordIdx <= cap_addr[1:0];
              MDataOut <= '0;
            end
          end
        end
        BURST: begin
          if (burst_idx == LAST_IDX) begin
            state     <= IDLE;
            burst_idx <= '0;
            MRdy      <= 1'b0;
            MDataOut  <= '0;
            MWordIdx  <= '0;
          end else begin
            burst_idx <= burst_idx + 2'd1;
            MWordIdx  <= burst_idx + 2'd1;
            MDataOut  <= mem[line_word(cap_addr, burst_idx + 2'd1)];
          end
        end
        WRACK: begin
          state    <= IDLE;
          MRdy     <= 1'b0;
          MDataOut <= '0;
          MWordIdx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, meaning wait cycles before a response (legal range 1..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning storage size in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MStrobe  input  1  request strobe from the cache controller.
REQ-006 SHALL have port MRW  input  1  request type: 1 = line read, 0 = single-word write.
REQ-007 SHALL have port MAddr  input  8  word address.
REQ-008 SHALL have port MDataIn  input  32  write data.
REQ-009 SHALL have port MDataOut  output  32  read data word.
REQ-010 SHALL have port MWordIdx  output  2  index within the line of the word on MDataOut.
REQ-011 SHALL have port MRdy  output  1  asserted high when read data is valid or a write has been committed.
REQ-012 SHALL have port MBusy  output  1  asserted high while a request is in progress.

Function
REQ-013 SHALL implement the states IDLE, WAIT, BURST and WRACK.
REQ-014 SHALL sample MStrobe only in IDLE.
  - On MStrobe=1 in IDLE: capture MRW, MAddr and MDataIn, load the latency counter with MEM_LAT-1, and go to WAIT.
REQ-015 SHALL ignore MStrobe in every state other than IDLE; no queuing and no error indication.
REQ-016 SHALL decrement the counter in WAIT.
  - When the counter is 0: go to BURST if the captured MRW=1, otherwise go to WRACK.
REQ-017 SHALL number cycles so that cycle 1 is the first cycle after the edge that sampled MStrobe.
  - WAIT occupies cycles 1..MEM_LAT.
  - BURST or WRACK begins in cycle MEM_LAT+1.
REQ-018 SHALL deliver a read line in BURST.
  - 4 consecutive cycles, words at {captured MAddr[7:2], idx}, idx = 0,1,2,3.
  - MRdy=1 in each of those cycles; MWordIdx=idx; MDataOut=memory word.
  - After idx=3, go to IDLE.
REQ-019 SHALL ignore the captured MAddr[1:0] for reads; line fills always start at word 0.
REQ-020 SHALL handle a write in WRACK, which lasts 1 cycle.
  - The captured MDataIn is written to the captured MAddr at the end of that cycle.
  - MRdy=1 and MWordIdx=captured MAddr[1:0] during that cycle; then go to IDLE.
REQ-021 SHALL assert MBusy in every state except IDLE, and MBusy SHALL be combinational from state.
REQ-022 SHALL keep MRdy=0 outside BURST and WRACK.
REQ-023 SHALL hold MDataOut at 0 whenever MRdy=0.
REQ-024 SHALL let a read issued in the cycle after a write's WRACK return the newly written data.
REQ-025 SHALL use only MAddr[$clog2(DEPTH)-1:0] when DEPTH<256; upper bits are ignored (address wraps).
REQ-026 SHALL allow the earliest back-to-back request in the first IDLE cycle after completion.
  - Read: cycle MEM_LAT+5.
  - Write: cycle MEM_LAT+2.

Reset
REQ-027 SHALL on reset=1, at any time, immediately force:
  - state=IDLE, counter=0, burst index=0, captured registers=0;
  - MRdy=0, MBusy=0, MDataOut=0, MWordIdx=0.
REQ-028 SHALL discard an in-flight request on reset.
  - A write not yet in WRACK SHALL NOT modify memory.
  - A burst stops with no further MRdy.
REQ-029 SHALL NOT clear storage contents on reset; contents persist across reset.
REQ-030 SHALL accept MStrobe on the first rising edge at which reset=0.

Structure
REQ-031 SHALL take the following from shared package mem_pkg:
  - the state enum (IDLE, WAIT, BURST, WRACK);
  - LINE_WORDS=4, DATA_W=32, ADDR_W=8, MEM_LAT default.
REQ-032 SHALL place the latency counter in sub-module mem_lat_ctr.
  - Inputs: load, load value, decrement enable.
  - Output: zero flag.
REQ-033 SHALL hold storage as a DEPTH x 32 register array inside mem_responder; no vendor macro.

Verification
REQ-034 SHALL cover write-then-read at MEM_LAT=4.
  - Write 0xDEADBEEF to addr 0x12 -> MRdy only in cycle 5, MBusy cycles 1-5.
  - Then read addr 0x10 -> MRdy cycles 5-8, MWordIdx 0..3, word 2 = 0xDEADBEEF.
REQ-035 SHALL cover a line read with preloaded addr 0x20..0x23 = 0xA0..0xA3, MStrobe with MAddr=0x22.
  - Data in order 0xA0, 0xA1, 0xA2, 0xA3.
REQ-036 SHALL cover MStrobe pulsed in cycle 3 of a read.
  - It is ignored: exactly 4 MRdy pulses, then IDLE.
REQ-037 SHALL cover reset asserted in cycle 3 of a write of 0x55 to addr 0x40.
  - MRdy/MBusy drop to 0 immediately.
  - A later read of 0x40 returns the prior value.
REQ-038 SHALL cover MEM_LAT=1 with back-to-back reads.
  - MRdy cycles 2-5, second MStrobe in cycle 6 accepted, its MRdy in cycles 8-11.
REQ-039 SHALL cover DEPTH=64 with a write to addr 0xC5.
  - Data lands at word 0x05; a read of 0x04 returns it at MWordIdx=1.
